mem_op_tracker: RTL and testbench
=================================

# mem_op_tracker

Tracks in-flight vector memory operations between the request/segment sequencing front-end and the VLSU in the Ara backend. It counts accepted load and store requests, retires them on per-operation completion pulses from the VLSU, and emits registered `load_complete_o` / `store_complete_o` pulses. It also provides an idle indication and a full/stall indication that throttles issue. Its completion and idle outputs feed the segment sequencer's `load_complete_i`, `store_complete_i` and `ara_idle_i`-style inputs.

## Interface

Parameters:
- `MaxOutstanding`, default 8: maximum in-flight memory ops (loads + stores), must be ≥1.
- `CntWidth`, default `$clog2(MaxOutstanding+1)`: derived, do not override.

Ports (clock and reset first):
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  synchronous clear of all tracking state.
- `issue_valid_i`  in  1  request valid toward the backend.
- `issue_ready_i`  in  1  backend ready; issue event = `valid & ready & is_mem`.
- `issue_is_mem_i`  in  1  request is a vector memory op.
- `issue_is_load_i`  in  1  1 = load, 0 = store; sampled on issue event.
- `load_done_i`  in  1  VLSU pulse, one load retired.
- `store_done_i`  in  1  VLSU pulse, one store retired.
- `load_cnt_o`  out  CntWidth  outstanding loads (registered).
- `store_cnt_o`  out  CntWidth  outstanding stores (registered).
- `full_o`  out  1  `load_cnt_o + store_cnt_o == MaxOutstanding`.
- `idle_o`  out  1  both counters zero.
- `load_complete_o`  out  1  one-cycle pulse per accepted load retirement.
- `store_complete_o`  out  1  one-cycle pulse per accepted store retirement.
- `err_o`  out  1  sticky protocol-violation flag.

## Operation

- State: `load_cnt_q`, `store_cnt_q`, `ld_pulse_q`, `st_pulse_q`, `err_q`. No other storage.
- Retirement acceptance:
  - `load_done_i` is accepted iff `load_cnt_q != 0`, or a load issue event happens in the same cycle.
  - Store retirement follows the same rule with `store_cnt_q` and store issue events.
- A rejected done (underflow) sets `err_q`, leaves the counter unchanged, and produces no pulse.
- Issue acceptance: the issue event is accepted iff at least one of these holds:
  - `total_q < MaxOutstanding`, or
  - a done of either type is accepted in the same cycle.
- A rejected issue (overflow) sets `err_q` and leaves the counters unchanged.
- Counter update per type: `+1` on accepted issue, `-1` on accepted done. Same-type issue and done in one cycle leaves the count unchanged. Arithmetic is unsigned, `CntWidth` wide. Wrap-around is impossible by construction.
- Pulses: `ld_pulse_q <= accepted load done`, `st_pulse_q <= accepted store done`. Load and store pulses may be high in the same cycle.
- `flush_i` has priority over everything:
  - next state is counters = 0, pulses = 0, `err_q = 0`;
  - issue and done events in that cycle are discarded.
- `full_o` and `idle_o` are combinational from registered counters only. There is no input-to-output combinational path.
- `err_o` stays set until reset or flush.

## Timing

- Reset values: `load_cnt_o = 0`, `store_cnt_o = 0`, `full_o = 0`, `idle_o = 1`, `load_complete_o = 0`, `store_complete_o = 0`, `err_o = 0`.
- Reset mid-operation: all state returns to reset values asynchronously. In-flight ops are forgotten, with no pulse.
- Issue → counter visible: 1 cycle. `idle_o` drops the cycle after the first accepted issue.
- Done → completion pulse: exactly 1 cycle latency, 1 cycle wide.
- Done → counter: the counter updates in the same edge as the pulse is registered. `idle_o` rises in the same cycle the last pulse is visible.
- `full_o` deasserts the cycle after an accepted done from a full state, unless a simultaneous issue was accepted.
- Back-to-back dones every cycle give back-to-back pulses with no bubble.

## Test plan

- Reset, then 3 load issues on consecutive cycles, then 3 `load_done_i` pulses:
  - `load_cnt_o` goes 1,2,3,2,1,0;
  - 3 consecutive `load_complete_o` pulses, each one cycle after its done;
  - `idle_o` = 1 on the cycle the third pulse is high;
  - `err_o` = 0.
- Fill to 8 (5 loads, 3 stores):
  - `full_o` = 1.
  - Next, issue a store with no done: rejected, `store_cnt_o` stays 3, `err_o` = 1.
  - Next, issue a store together with `load_done_i`: accepted, load 4, store 4, `load_complete_o` pulse, `full_o` stays 1.
- With `load_cnt_o` = 1, drive a load issue and `load_done_i` in the same cycle:
  - count stays 1, one `load_complete_o` pulse, `idle_o` stays 0.
- With counters 0, drive `store_done_i`:
  - `err_o` = 1, `store_cnt_o` = 0, no `store_complete_o`.
  - Then `flush_i`: `err_o` = 0.
- With load 2, store 1, drive `flush_i` together with `load_done_i` and a store issue:
  - next cycle counters 0, no pulse, `idle_o` = 1.
- With load 2, store 2, drive `load_done_i` and `store_done_i` together:
  - next cycle both pulses high, counts 1/1.
  - Assert `rst_ni` low mid-cycle: outputs return to reset values immediately.

Source files
------------

// File: rtl/mem_op_tracker.sv
// In-flight vector memory operation tracker: counts accepted loads/stores,
// retires them on VLSU done pulses and flags protocol violations.
module mem_op_tracker #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic                issue_ready_i,
  input  logic                issue_is_mem_i,
  input  logic                issue_is_load_i,
  input  logic                load_done_i,
  input  logic                store_done_i,
  output logic [CntWidth-1:0] load_cnt_o,
  output logic [CntWidth-1:0] store_cnt_o,
  output logic                full_o,
  output logic                idle_o,
  output logic                load_complete_o,
  output logic                store_complete_o,
  output logic                err_o
);

  localparam int unsigned TotWidth = CntWidth + 1;
  localparam logic [TotWidth-1:0] MaxTotal = TotWidth'(MaxOutstanding);

  logic [CntWidth-1:0] load_cnt_q, load_cnt_d;
  logic [CntWidth-1:0] store_cnt_q, store_cnt_d;
  logic                ld_pulse_q, ld_pulse_d;
  logic                st_pulse_q, st_pulse_d;
  logic                err_q, err_d;

  logic [TotWidth-1:0] total_q;
  logic                issue_ev, ld_issue_ev, st_issue_ev;
  logic                ld_done_acc, st_done_acc, issue_acc;

  assign total_q     = {1'b0, load_cnt_q} + {1'b0, store_cnt_q};
  assign issue_ev    = issue_valid_i & issue_ready_i & issue_is_mem_i;
  assign ld_issue_ev = issue_ev & issue_is_load_i;
  assign st_issue_ev = issue_ev & ~issue_is_load_i;

  // A done is legal against an empty counter only if a same-type issue
  // lands in the same cycle; that issue is then always accepted.
  assign ld_done_acc = load_done_i & ((load_cnt_q != '0) | ld_issue_ev);
  assign st_done_acc = store_done_i & ((store_cnt_q != '0) | st_issue_ev);
  assign issue_acc   = issue_ev & ((total_q < MaxTotal) | ld_done_acc | st_done_acc);

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    ld_pulse_d  = 1'b0;
    st_pulse_d  = 1'b0;
    err_d       = err_q;

    if (flush_i) begin
      load_cnt_d  = '0;
      store_cnt_d = '0;
      err_d       = 1'b0;
    end else begin
      load_cnt_d  = load_cnt_q + CntWidth'(ld_issue_ev & issue_acc)
                               - CntWidth'(ld_done_acc);
      store_cnt_d = store_cnt_q + CntWidth'(st_issue_ev & issue_acc)
                                - CntWidth'(st_done_acc);
      ld_pulse_d  = ld_done_acc;
      st_pulse_d  = st_done_acc;
      if ((load_done_i & ~ld_done_acc) | (store_done_i & ~st_done_acc) |
          (issue_ev & ~issue_acc)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      ld_pulse_q  <= 1'b0;
      st_pulse_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      ld_pulse_q  <= ld_pulse_d;
      st_pulse_q  <= st_pulse_d;
      err_q       <= err_d;
    end
  end

  assign load_cnt_o       = load_cnt_q;
  assign store_cnt_o      = store_cnt_q;
  assign full_o           = (total_q == MaxTotal);
  assign idle_o           = (load_cnt_q == '0) && (store_cnt_q == '0);
  assign load_complete_o  = ld_pulse_q;
  assign store_complete_o = st_pulse_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_mem_op_tracker.sv
// Bench for mem_op_tracker: directed scenarios then random traffic, all
// compared against an integer reference model of outstanding operations.
module tb_mem_op_tracker;

  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i, issue_valid_i, issue_ready_i, issue_is_mem_i, issue_is_load_i;
  logic          load_done_i, store_done_i;
  logic [CW-1:0] load_cnt_o, store_cnt_o;
  logic          full_o, idle_o, load_complete_o, store_complete_o, err_o;

  int checks = 0;
  int errors = 0;

  // reference model: outstanding counts as plain integers
  int m_ld, m_st;
  bit m_err, m_lp, m_sp;

  always #5 clk_i = ~clk_i;

  mem_op_tracker #(.MaxOutstanding(MAX)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_i   (issue_ready_i),
    .issue_is_mem_i  (issue_is_mem_i),
    .issue_is_load_i (issue_is_load_i),
    .load_done_i     (load_done_i),
    .store_done_i    (store_done_i),
    .load_cnt_o      (load_cnt_o),
    .store_cnt_o     (store_cnt_o),
    .full_o          (full_o),
    .idle_o          (idle_o),
    .load_complete_o (load_complete_o),
    .store_complete_o(store_complete_o),
    .err_o           (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ld = 0; m_st = 0; m_err = 0; m_lp = 0; m_sp = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":load_cnt"},  32'(load_cnt_o),       32'(m_ld));
    chk({ctx, ":store_cnt"}, 32'(store_cnt_o),      32'(m_st));
    chk({ctx, ":full"},      32'(full_o),           32'(m_ld + m_st == MAX));
    chk({ctx, ":idle"},      32'(idle_o),           32'(m_ld == 0 && m_st == 0));
    chk({ctx, ":ld_pulse"},  32'(load_complete_o),  32'(m_lp));
    chk({ctx, ":st_pulse"},  32'(store_complete_o), 32'(m_sp));
    chk({ctx, ":err"},       32'(err_o),            32'(m_err));
  endtask

  // One clock of stimulus; model advances on the same edge, outputs checked 1ns later.
  task automatic cyc(input string ctx, input bit fl, input bit v, input bit r, input bit m,
                     input bit il, input bit ld, input bit sd);
    bit ev, lev, sev, lacc, sacc, iacc;
    flush_i = fl; issue_valid_i = v; issue_ready_i = r; issue_is_mem_i = m;
    issue_is_load_i = il; load_done_i = ld; store_done_i = sd;
    @(posedge clk_i);
    #1;
    if (fl) begin
      model_reset();
    end else begin
      ev   = v && r && m;
      lev  = ev && il;
      sev  = ev && !il;
      lacc = ld && (m_ld > 0 || lev);
      sacc = sd && (m_st > 0 || sev);
      iacc = ev && ((m_ld + m_st) < MAX || lacc || sacc);
      if ((ld && !lacc) || (sd && !sacc) || (ev && !iacc)) m_err = 1;
      if (iacc && lev) m_ld++;
      if (iacc && sev) m_st++;
      if (lacc) m_ld--;
      if (sacc) m_st--;
      m_lp = lacc;
      m_sp = sacc;
    end
    check_all(ctx);
    $display("%s fl=%0b iss=%0b ld=%0b ldd=%0b std=%0b -> lc=%0d sc=%0d full=%0b idle=%0b lp=%0b sp=%0b err=%0b",
             ctx, fl, v & r & m, il, ld, sd, load_cnt_o, store_cnt_o, full_o, idle_o,
             load_complete_o, store_complete_o, err_o);
  endtask

  task automatic iss_ld(input string ctx);  cyc(ctx, 0, 1, 1, 1, 1, 0, 0); endtask
  task automatic iss_st(input string ctx);  cyc(ctx, 0, 1, 1, 1, 0, 0, 0); endtask
  task automatic idle_cyc(input string ctx); cyc(ctx, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 0; issue_valid_i = 0; issue_ready_i = 0; issue_is_mem_i = 0;
    issue_is_load_i = 0; load_done_i = 0; store_done_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    chk("reset:idle_const", 32'(idle_o), 32'd1);
    #3 rst_ni = 1'b1;

    // three loads then three retirements
    iss_ld("ld3"); iss_ld("ld3"); iss_ld("ld3");
    chk("ld3:cnt3", 32'(load_cnt_o), 32'd3);
    cyc("ld3done", 0, 0, 0, 0, 0, 1, 0);
    cyc("ld3done", 0, 0, 0, 0, 0, 1, 0);
    cyc("ld3done", 0, 0, 0, 0, 0, 1, 0);
    chk("ld3:idle_on_last_pulse", 32'({idle_o, load_complete_o}), 32'b11);
    idle_cyc("ld3tail");
    chk("ld3:no_err", 32'(err_o), 32'd0);

    // fill to capacity, overflow, then issue paired with a retirement
    repeat (5) iss_ld("fill");
    repeat (3) iss_st("fill");
    chk("fill:full", 32'(full_o), 32'd1);
    iss_st("ovf");
    chk("ovf:store_cnt", 32'(store_cnt_o), 32'd3);
    chk("ovf:err", 32'(err_o), 32'd1);
    cyc("swap", 0, 1, 1, 1, 0, 1, 0);
    chk("swap:counts", 32'({load_cnt_o, store_cnt_o}), 32'({4'(4), 4'(4)}));
    chk("swap:full", 32'(full_o), 32'd1);
    cyc("flush1", 1, 0, 0, 0, 0, 0, 0);

    // same-cycle load issue and retirement
    iss_ld("same");
    cyc("same", 0, 1, 1, 1, 1, 1, 0);
    chk("same:cnt", 32'(load_cnt_o), 32'd1);
    chk("same:idle", 32'(idle_o), 32'd0);
    cyc("drain", 0, 0, 0, 0, 0, 1, 0);

    // underflow, then flush clears err
    idle_cyc("udf_pre");
    cyc("udf", 0, 0, 0, 0, 0, 0, 1);
    chk("udf:err", 32'(err_o), 32'd1);
    chk("udf:no_pulse", 32'(store_complete_o), 32'd0);
    cyc("udf_flush", 1, 0, 0, 0, 0, 0, 0);
    chk("udf_flush:err", 32'(err_o), 32'd0);

    // flush overrides simultaneous done and issue
    iss_ld("fpri"); iss_ld("fpri"); iss_st("fpri");
    cyc("fpri", 1, 1, 1, 1, 0, 1, 0);
    chk("fpri:idle", 32'(idle_o), 32'd1);

    // dual retirement, then asynchronous reset mid-cycle
    iss_ld("dual"); iss_ld("dual"); iss_st("dual"); iss_st("dual");
    cyc("dual", 0, 0, 0, 0, 0, 1, 1);
    chk("dual:pulses", 32'({load_complete_o, store_complete_o}), 32'b11);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #3 rst_ni = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc("rand", ($urandom_range(0, 47) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0),
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
